// File: rtl/cim_mvm_ctrl_if.sv
// Command, result and CIM-macro pin bundle for cim_mvm_ctrl.
// The slave modport is the sequencer; the master modport is the command source, result sink and macro.
interface cim_mvm_ctrl_if #(
  parameter int CIM_INPUT_PRECISION    = 4,
  parameter int CIM_INPUT_PARALLELISM  = 8,
  parameter int CIM_OUTPUT_PARALLELISM = 8,
  parameter int ACC_WIDTH              = 32
);
  localparam int ACT_W = 2 * CIM_INPUT_PRECISION * CIM_INPUT_PARALLELISM;
  localparam int NIB_W = CIM_INPUT_PRECISION * CIM_INPUT_PARALLELISM;
  localparam int IDX_W = $clog2(CIM_OUTPUT_PARALLELISM);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_addr;
  logic [ACT_W-1:0]     cmd_act;

  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic [IDX_W-1:0]     res_idx;
  logic                 res_last;

  logic                 cim_cs;
  logic                 cim_write;
  logic                 cim_en;
  logic                 cim_partial_sum;
  logic                 cim_reset_output;
  logic [3:0]           cim_output_reg;
  logic [31:0]          cim_address;
  logic [NIB_W-1:0]     cim_input_data;
  logic [ACC_WIDTH-1:0] cim_output;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_act, res_ready, cim_output,
    output cmd_ready, res_valid, res_data, res_idx, res_last,
           cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output,
           cim_output_reg, cim_address, cim_input_data
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_act, res_ready, cim_output,
    input  cmd_ready, res_valid, res_data, res_idx, res_last,
           cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output,
           cim_output_reg, cim_address, cim_input_data
  );
endinterface

// File: rtl/cim_mvm_ctrl.sv
// Bit-serial CIM matrix-vector sequencer: two nibble passes, shift-add combine, valid/ready result stream.
// Optional macro CIM_MVM_RELU_EN clamps negative combined results to zero.
module cim_mvm_ctrl #(
  parameter int CIM_INPUT_PRECISION    = 4,
  parameter int CIM_INPUT_PARALLELISM  = 8,
  parameter int CIM_OUTPUT_PARALLELISM = 8,
  parameter int ACC_WIDTH              = 32
) (
  input  logic          clk,
  input  logic          rst,
  cim_mvm_ctrl_if.slave bus
);
  localparam int P     = CIM_INPUT_PRECISION;
  localparam int ACT_W = 2 * P * CIM_INPUT_PARALLELISM;
  localparam int NIB_W = P * CIM_INPUT_PARALLELISM;
  localparam int IDX_W = $clog2(CIM_OUTPUT_PARALLELISM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CIM_OUTPUT_PARALLELISM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_LO, S_ACC_LO, S_RD_LO, S_CLR_HI, S_ACC_HI, S_RD_HI, S_OUT
  } state_t;

  state_t                      state;
  logic [ACT_W-1:0]            act_q;
  logic [IDX_W-1:0]            rd_idx;
  logic [IDX_W-1:0]            rd_nxt;
  logic [IDX_W-1:0]            res_nxt;
  logic signed [ACC_WIDTH-1:0] lo_q  [CIM_OUTPUT_PARALLELISM];
  logic signed [ACC_WIDTH-1:0] res_q [CIM_OUTPUT_PARALLELISM];

  function automatic logic [NIB_W-1:0] slice_nibbles(input logic [ACT_W-1:0] act,
                                                     input logic             hi);
    logic [NIB_W-1:0] s;
    s = '0;
    for (int i = 0; i < CIM_INPUT_PARALLELISM; i++) begin
      s[i*P +: P] = hi ? act[i*2*P + P +: P] : act[i*2*P +: P];
    end
    return s;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] shift_add(input logic signed [ACC_WIDTH-1:0] lo,
                                                            input logic signed [ACC_WIDTH-1:0] hi);
    return lo + (hi <<< P);
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] relu_clamp(input logic signed [ACC_WIDTH-1:0] v);
`ifdef CIM_MVM_RELU_EN
    return v[ACC_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign rd_nxt  = rd_idx + IDX_W'(1);
  assign res_nxt = bus.res_idx + IDX_W'(1);

  // Control FSM; every macro pin is registered so it is valid for the whole named state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      act_q                <= '0;
      rd_idx               <= '0;
      bus.cmd_ready        <= 1'b1;
      bus.res_valid        <= 1'b0;
      bus.res_data         <= '0;
      bus.res_idx          <= '0;
      bus.res_last         <= 1'b0;
      bus.cim_cs           <= 1'b0;
      bus.cim_write        <= 1'b0;
      bus.cim_en           <= 1'b0;
      bus.cim_partial_sum  <= 1'b0;
      bus.cim_reset_output <= 1'b0;
      bus.cim_output_reg   <= '0;
      bus.cim_address      <= '0;
      bus.cim_input_data   <= '0;
    end else begin
      bus.cim_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            act_q                <= bus.cmd_act;
            bus.cmd_ready        <= 1'b0;
            bus.cim_cs           <= 1'b1;
            bus.cim_en           <= 1'b1;
            bus.cim_reset_output <= 1'b1;
            bus.cim_partial_sum  <= 1'b0;
            bus.cim_address      <= bus.cmd_addr;
            bus.cim_input_data   <= '0;
            state                <= S_CLR_LO;
          end
        end
        S_CLR_LO, S_CLR_HI: begin
          bus.cim_reset_output <= 1'b0;
          bus.cim_partial_sum  <= 1'b1;
          bus.cim_input_data   <= slice_nibbles(act_q, state == S_CLR_HI);
          state                <= (state == S_CLR_LO) ? S_ACC_LO : S_ACC_HI;
        end
        S_ACC_LO, S_ACC_HI: begin
          bus.cim_cs          <= 1'b0;
          bus.cim_partial_sum <= 1'b0;
          bus.cim_input_data  <= '0;
          bus.cim_output_reg  <= '0;
          rd_idx              <= '0;
          state               <= (state == S_ACC_LO) ? S_RD_LO : S_RD_HI;
        end
        S_RD_LO, S_RD_HI: begin
          if (rd_idx != LAST_IDX) begin
            rd_idx             <= rd_nxt;
            bus.cim_output_reg <= 4'(rd_nxt);
          end else if (state == S_RD_LO) begin
            bus.cim_cs           <= 1'b1;
            bus.cim_reset_output <= 1'b1;
            bus.cim_output_reg   <= '0;
            state                <= S_CLR_HI;
          end else begin
            // res_q[0] was written during the first RD_HI cycle, so it is ready to present now.
            bus.cim_en         <= 1'b0;
            bus.cim_output_reg <= '0;
            bus.cim_address    <= '0;
            bus.res_valid      <= 1'b1;
            bus.res_idx        <= '0;
            bus.res_last       <= (LAST_IDX == '0);
            bus.res_data       <= relu_clamp(res_q[0]);
            state              <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            if (bus.res_last) begin
              bus.res_valid <= 1'b0;
              bus.res_last  <= 1'b0;
              bus.res_idx   <= '0;
              bus.cmd_ready <= 1'b1;
              state         <= S_IDLE;
            end else begin
              bus.res_idx  <= res_nxt;
              bus.res_data <= relu_clamp(res_q[res_nxt]);
              bus.res_last <= (res_nxt == LAST_IDX);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath capture of each drained output register; low pass stored, high pass shift-added.
  always_ff @(posedge clk) begin
    if (state == S_RD_LO) begin
      lo_q[rd_idx] <= $signed(bus.cim_output);
    end
    if (state == S_RD_HI) begin
      res_q[rd_idx] <= shift_add(lo_q[rd_idx], $signed(bus.cim_output));
    end
  end
endmodule

// File: tb/tb_cim_mvm_ctrl.sv
// Self-checking bench for cim_mvm_ctrl with a behavioural CIM macro (signed weight matrix).
// Expected results come from a direct dot product of weights and full 8-bit activations.
module tb_cim_mvm_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cim_mvm_ctrl_if bus();
  cim_mvm_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: weights w[k][i], eight output registers, optional fixed per-pass values.
  int          w [8][8];
  int          out_reg [8] = '{default: 0};
  bit          fix_mode = 1'b0;
  int          fix_lo = 0;
  int          fix_hi = 0;
  bit          parity = 1'b0;
  logic [31:0] acc_lo_seen = '0;
  logic [31:0] acc_hi_seen = '0;
  logic [31:0] cur_addr = '0;
  int          cim_cycles = 0;
  int          addr_err = 0;
  int          write_err = 0;
  int          stall_err = 0;

  function automatic int dot(int k, logic [31:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += w[k][i] * int'({28'b0, d[(7-i)*4 +: 4]});
    return s;
  endfunction

  always @(posedge clk) begin
    if (bus.cim_write) write_err <= write_err + 1;
    if (bus.cim_en) begin
      cim_cycles <= cim_cycles + 1;
      if (bus.cim_address !== cur_addr) addr_err <= addr_err + 1;
    end
    if (bus.res_valid && bus.cim_en) stall_err <= stall_err + 1;
    if (bus.cim_cs && bus.cim_en && bus.cim_reset_output) begin
      for (int k = 0; k < 8; k++) out_reg[k] <= 0;
    end else if (bus.cim_cs && bus.cim_en && bus.cim_partial_sum) begin
      parity <= ~parity;
      if (!parity) acc_lo_seen <= bus.cim_input_data;
      else         acc_hi_seen <= bus.cim_input_data;
      for (int k = 0; k < 8; k++)
        out_reg[k] <= fix_mode ? (parity ? fix_hi : fix_lo) : out_reg[k] + dot(k, bus.cim_input_data);
    end
  end

  assign bus.cim_output = 32'(out_reg[bus.cim_output_reg[2:0]]);

  // Reference: result column k = sum_i w[k][i] * act_i, with optional clamp.
  function automatic int model_res(int k, logic [63:0] act);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++) s += w[k][i] * int'({24'b0, act[(7-i)*8 +: 8]});
    return s;
  endfunction

  function automatic logic [31:0] post(int raw);
`ifdef CIM_MVM_RELU_EN
    return (raw < 0) ? 32'd0 : 32'(raw);
`else
    return 32'(raw);
`endif
  endfunction

  task automatic randomize_weights();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) w[k][i] = int'($urandom_range(15)) - 8;
  endtask

  int acc_cyc;
  task automatic issue_cmd(input logic [31:0] a, input logic [63:0] act);
    int n;
    bus.cmd_addr  = a;
    bus.cmd_act   = act;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL cmd_accept: cmd_ready never rose within 500 cycles");
    end
    @(posedge clk); #1;
    acc_cyc       = cyc;
    cur_addr      = a;
    bus.cmd_valid = 1'b0;
  endtask

  logic [31:0] got_data [8];
  int          got_idx  [8];
  bit          got_last [8];
  int          got_cyc  [8];
  int          n_got, first_valid_cyc, stab_err, early;

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready.
  task automatic collect(input int mode);
    bit          ready, stalled;
    logic [31:0] h_data;
    logic [2:0]  h_idx;
    int          t;
    n_got = 0; first_valid_cyc = -1; stab_err = 0; early = 0;
    stalled = 1'b0; h_data = '0; h_idx = '0; t = 0;
    while (n_got < 8 && t < 400) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (t % 3 == 0);
        default: ready = 1'($urandom_range(1));
      endcase
      bus.res_ready = ready;
      if (bus.cmd_ready) early++;
      if (bus.res_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled && (!bus.res_valid || bus.res_data !== h_data || bus.res_idx !== h_idx)) stab_err++;
      if (bus.res_valid && ready) begin
        got_data[n_got] = bus.res_data;
        got_idx[n_got]  = int'(bus.res_idx);
        got_last[n_got] = bus.res_last;
        got_cyc[n_got]  = cyc;
        n_got++;
      end
      stalled = bus.res_valid && !ready;
      h_data  = bus.res_data;
      h_idx   = bus.res_idx;
      @(posedge clk); #1; t++;
    end
    bus.res_ready = 1'b0;
    if (n_got < 8) begin
      tests++; fails++;
      $display("FAIL collect_timeout: got %0d results, required 8", n_got);
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_act = '0; bus.res_ready = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b need 1", bus.cmd_ready); end
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b need 0", bus.res_valid); end
    tests++; if ({bus.cim_cs, bus.cim_en, bus.cim_write, bus.cim_partial_sum, bus.cim_reset_output} !== 5'b0) begin
      fails++; $display("FAIL reset_cim_ctl: got %b need 00000", {bus.cim_cs, bus.cim_en, bus.cim_write, bus.cim_partial_sum, bus.cim_reset_output}); end
    tests++; if ({bus.res_data, bus.res_idx, bus.res_last} !== 36'h0) begin
      fails++; $display("FAIL reset_res_regs: got %h/%0d/%b need 0", bus.res_data, bus.res_idx, bus.res_last); end
    tests++; if ({bus.cim_address, bus.cim_input_data, bus.cim_output_reg} !== 68'h0) begin
      fails++; $display("FAIL reset_cim_bus: got %h %h %h need 0", bus.cim_address, bus.cim_input_data, bus.cim_output_reg); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.cmd_ready !== 1'b1 || bus.cim_en !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: cmd_ready=%b cim_en=%b need 1/0", bus.cmd_ready, bus.cim_en); end
  endtask

  task automatic test_pack_latency();
    int c0, a0;
    fix_mode = 1'b1; fix_lo = 3; fix_hi = 2;
    c0 = cim_cycles; a0 = addr_err;
    issue_cmd(32'h40, 64'h0123456789ABCDEF);
    collect(0);
    tests++; if (acc_lo_seen !== 32'h13579BDF) begin fails++; $display("FAIL acc_lo_data: got %h need 13579bdf", acc_lo_seen); end
    tests++; if (acc_hi_seen !== 32'h02468ACE) begin fails++; $display("FAIL acc_hi_data: got %h need 02468ace", acc_hi_seen); end
    tests++; if (cim_cycles - c0 != 20) begin fails++; $display("FAIL cim_cycle_count: got %0d need 20", cim_cycles - c0); end
    tests++; if (addr_err != a0) begin fails++; $display("FAIL cim_address: %0d cycles off 0x40", addr_err - a0); end
    tests++; if (first_valid_cyc - acc_cyc != 20) begin fails++; $display("FAIL first_latency: got %0d need 20", first_valid_cyc - acc_cyc); end
    for (int k = 0; k < n_got; k++) begin
      tests++; if (got_data[k] !== 32'd35 || got_idx[k] != k || got_last[k] != (k == 7)) begin
        fails++; $display("FAIL fixed35_res%0d: got %h idx %0d last %b need 23 idx %0d", k, got_data[k], got_idx[k], got_last[k], k); end
      tests++; if (got_cyc[k] != got_cyc[0] + k) begin
        fails++; $display("FAIL back_to_back%0d: got cycle %0d need %0d", k, got_cyc[k], got_cyc[0] + k); end
    end
    tests++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_last: got %b need 1", bus.cmd_ready); end
  endtask

  task automatic test_negative();
    logic [31:0] exp_v;
`ifdef CIM_MVM_RELU_EN
    exp_v = 32'h0;
`else
    exp_v = 32'hFFFFFFF5;
`endif
    fix_mode = 1'b1; fix_lo = 5; fix_hi = -1;
    issue_cmd(32'h1000, 64'hFFEEDDCCBBAA9988);
    collect(0);
    for (int k = 0; k < n_got; k++) begin
      tests++; if (got_data[k] !== exp_v) begin fails++; $display("FAIL negative_res%0d: got %h need %h", k, got_data[k], exp_v); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, a2;
    logic [63:0] act1, act2;
    int s0, cy;
    fix_mode = 1'b0; randomize_weights();
    a1 = $urandom; a2 = $urandom;
    act1 = {$urandom, $urandom}; act2 = {$urandom, $urandom};
    s0 = stall_err;
    issue_cmd(a1, act1);
    bus.cmd_addr = a2; bus.cmd_act = act2; bus.cmd_valid = 1'b1;
    collect(1);
    tests++; if (stab_err != 0) begin fails++; $display("FAIL stall_stable: %0d unstable cycles need 0", stab_err); end
    tests++; if (early != 0) begin fails++; $display("FAIL early_accept: cmd_ready high %0d cycles before res_last need 0", early); end
    tests++; if (stall_err != s0) begin fails++; $display("FAIL cim_during_out: %0d active cycles need 0", stall_err - s0); end
    for (int k = 0; k < n_got; k++) begin
      tests++; if (got_data[k] !== post(model_res(k, act1)) || got_idx[k] != k) begin
        fails++; $display("FAIL bp_res%0d: got %h idx %0d need %h idx %0d", k, got_data[k], got_idx[k], post(model_res(k, act1)), k); end
    end
    cy = cyc;
    issue_cmd(a2, act2);
    tests++; if (acc_cyc != cy + 1) begin fails++; $display("FAIL held_cmd_accept: accepted at +%0d need +1", acc_cyc - cy); end
    collect(0);
    for (int k = 0; k < n_got; k++) begin
      tests++; if (got_data[k] !== post(model_res(k, act2))) begin
        fails++; $display("FAIL second_cmd_res%0d: got %h need %h", k, got_data[k], post(model_res(k, act2))); end
    end
  endtask

  task automatic test_random();
    logic [63:0] act;
    fix_mode = 1'b0;
    for (int r = 0; r < 4; r++) begin
      randomize_weights();
      act = {$urandom, $urandom};
      issue_cmd($urandom, act);
      collect(2);
      for (int k = 0; k < n_got; k++) begin
        tests++; if (got_data[k] !== post(model_res(k, act)) || got_last[k] != (k == 7)) begin
          fails++; $display("FAIL random%0d_res%0d: got %h last %b need %h", r, k, got_data[k], got_last[k], post(model_res(k, act))); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] act;
    fix_mode = 1'b0; randomize_weights();
    issue_cmd(32'hDEAD0000, {$urandom, $urandom});
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if ({bus.cim_cs, bus.cim_en, bus.cim_partial_sum, bus.cim_reset_output, bus.cim_output_reg} !== 8'h0) begin
      fails++; $display("FAIL midrst_ctl: got %b need 0", {bus.cim_cs, bus.cim_en, bus.cim_partial_sum, bus.cim_reset_output, bus.cim_output_reg}); end
    tests++; if (bus.cim_address !== 32'h0 || bus.cim_input_data !== 32'h0) begin
      fails++; $display("FAIL midrst_bus: got %h %h need 0", bus.cim_address, bus.cim_input_data); end
    tests++; if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_hs: cmd_ready=%b res_valid=%b need 1/0", bus.cmd_ready, bus.res_valid); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    act = {$urandom, $urandom};
    issue_cmd(32'h80, act);
    tests++; if (!(bus.cim_cs && bus.cim_en && bus.cim_reset_output)) begin
      fails++; $display("FAIL restart_clr: cs/en/reset_output=%b%b%b need 111", bus.cim_cs, bus.cim_en, bus.cim_reset_output); end
    collect(0);
    for (int k = 0; k < n_got; k++) begin
      tests++; if (got_data[k] !== post(model_res(k, act))) begin
        fails++; $display("FAIL restart_res%0d: got %h need %h", k, got_data[k], post(model_res(k, act))); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_act   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_pack_latency();
    test_negative();
    test_backpressure();
    test_random();
    test_reset_mid();
    tests++; if (write_err != 0) begin fails++; $display("FAIL cim_write: high %0d cycles need 0", write_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
